// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - request/response bundle between load/store initiator and dmem_responder
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_addr, req_we, req_wdata, req_funct3,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_wdata, req_funct3,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - latency-modelling RV32I data-memory slave with lane select, masking and extension
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              rst,
  dmem_responder_if.slave   bus,
  output logic              busy
);
  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nx;
  logic [3:0]  cnt;
  logic [31:0] a_addr, a_wdata;
  logic        a_we;
  logic [2:0]  a_f3;
  logic        accept, exec;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx       = state;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    busy           = 1'b1;
    accept         = 1'b0;
    exec           = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        busy          = 1'b0;
        if (bus.req_valid) begin
          accept   = 1'b1;
          state_nx = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          exec     = 1'b1;
          state_nx = RESP;
        end
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        state_nx       = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= 4'd0;
      a_addr  <= '0;
      a_wdata <= '0;
      a_we    <= 1'b0;
      a_f3    <= 3'd0;
    end else if (accept) begin
      cnt     <= 4'(LATENCY - 1);
      a_addr  <= bus.req_addr;
      a_wdata <= bus.req_wdata;
      a_we    <= bus.req_we;
      a_f3    <= bus.req_funct3;
    end else if (state == WAIT && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  logic          f3_ok, misal, in_range, err;
  logic [1:0]    lane;
  logic [AW-1:0] word_idx;
  logic [31:0]   rword, load_val, wword;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [3:0]    be;

  assign lane     = a_addr[1:0];
  assign word_idx = a_addr[AW+1:2];
  assign in_range = ({2'b00, a_addr[31:2]} < 32'(DEPTH_WORDS));
  assign rword    = mem[word_idx];
  assign byte_sel = rword[8*lane +: 8];
  assign half_sel = a_addr[1] ? rword[31:16] : rword[15:0];
  assign err      = !f3_ok || misal || !in_range;

  // Width decode is shared by loads and stores; the unsigned codes exist only for loads.
  always_comb begin
    f3_ok    = 1'b0;
    misal    = 1'b0;
    load_val = 32'd0;
    be       = 4'b0000;
    wword    = a_wdata;
    case (a_f3)
      3'b000: begin
        f3_ok    = 1'b1;
        load_val = {{24{byte_sel[7]}}, byte_sel};
        be       = 4'b0001 << lane;
        wword    = {4{a_wdata[7:0]}};
      end
      3'b001: begin
        f3_ok    = 1'b1;
        misal    = a_addr[0];
        load_val = {{16{half_sel[15]}}, half_sel};
        be       = a_addr[1] ? 4'b1100 : 4'b0011;
        wword    = {2{a_wdata[15:0]}};
      end
      3'b010: begin
        f3_ok    = 1'b1;
        misal    = |a_addr[1:0];
        load_val = rword;
        be       = 4'b1111;
      end
      3'b100: begin
        f3_ok    = !a_we;
        load_val = {24'd0, byte_sel};
      end
      3'b101: begin
        f3_ok    = !a_we;
        misal    = a_addr[0];
        load_val = {16'd0, half_sel};
      end
      default: f3_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (exec && a_we && !err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[word_idx][8*b +: 8] <= wword[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else if (exec) begin
      rdata_q <= (err || a_we) ? 32'd0 : load_val;
      err_q   <= err;
    end
  end

  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
endmodule
